// File: rtl/micro_ucr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : micro_ucr_pkg
//  Description : Shared widths, scheduler state encoding and the target
//                comparison used by the hash scheduler and the core checkers.
//  Revision    : 1.0 - initial release
// ============================================================================
package micro_ucr_pkg;

    localparam int BYTE      = 8;
    localparam int HASH_W    = 24;
    localparam int BLOQUE_W  = 96;
    localparam int NONCE_W   = 32;
    // One core input word: block header followed by that core's nonce.
    localparam int ENTRADA_W = BLOQUE_W + NONCE_W;

    // Scheduler FSM encoding.
    localparam int              ST_W      = 3;
    localparam logic [ST_W-1:0] S_IDLE    = 3'd0;
    localparam logic [ST_W-1:0] S_LANZA   = 3'd1;
    localparam logic [ST_W-1:0] S_ESPERA  = 3'd2;
    localparam logic [ST_W-1:0] S_EVALUA  = 3'd3;
    localparam logic [ST_W-1:0] S_EXITO   = 3'd4;
    localparam logic [ST_W-1:0] S_AGOTADO = 3'd5;

    // A hash meets the target when both of its two upper bytes are strictly
    // below the difficulty byte (unsigned).
    function automatic logic cumple_target(input logic [HASH_W-1:0] hash,
                                           input logic [BYTE-1:0]   target);
        return (hash[HASH_W-1 -: BYTE] < target) &&
               (hash[HASH_W-BYTE-1 -: BYTE] < target);
    endfunction

endpackage
`default_nettype wire

// File: rtl/micro_ucr_target_check.sv
`default_nettype none
// ============================================================================
//  Module      : micro_ucr_target_check
//  Description : Combinational comparison of N core hashes against the
//                difficulty byte. Reports a per-core hit vector and the
//                index/hash of the lowest-numbered hitting core.
//  Ports       : i_hashes   core i hash in [HASH_W*i +: HASH_W]
//                i_target   difficulty byte
//                o_hit      per-core hit flags
//                o_win_idx  lowest hitting index (0 when no hit)
//                o_win_hash hash of that core (0 when no hit)
//  Revision    : 1.0 - initial release
// ============================================================================
module micro_ucr_target_check
    import micro_ucr_pkg::*;
#(
    parameter int NUM_BLOQUES_PARALELOS = 4,
    parameter int IDX_W                 = 2
) (
    input  logic [HASH_W*NUM_BLOQUES_PARALELOS-1:0] i_hashes,
    input  logic [BYTE-1:0]                         i_target,
    output logic [NUM_BLOQUES_PARALELOS-1:0]        o_hit,
    output logic [IDX_W-1:0]                        o_win_idx,
    output logic [HASH_W-1:0]                       o_win_hash
);

    for (genvar gi = 0; gi < NUM_BLOQUES_PARALELOS; gi++) begin : g_cmp
        assign o_hit[gi] = cumple_target(i_hashes[HASH_W*gi +: HASH_W], i_target);
    end

    // Scan from the top index down so the lowest hitting core is written last
    // and therefore wins.
    always_comb begin
        o_win_idx  = '0;
        o_win_hash = '0;
        for (int i = NUM_BLOQUES_PARALELOS - 1; i >= 0; i--) begin
            if (o_hit[i]) begin
                o_win_idx  = IDX_W'(i);
                o_win_hash = i_hashes[HASH_W*i +: HASH_W];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/micro_ucr_hash_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : micro_ucr_hash_scheduler
//  Description : Responder end of the miner job interface. Latches a job,
//                drives NUM_BLOQUES_PARALELOS lock-step hash cores, strides
//                their nonces each round and reports the first hash that
//                meets the target (terminado_out) or exhaustion (agotado_out).
//  Ports       : clk, reset (sync, active-high)
//                inicio            level job request / abort when low
//                bloque_datos      96-bit block header, byte 0 in [95:88]
//                nonce_iniciales   starting nonce of core i in [32*i +: 32]
//                target            difficulty byte
//                core_start        one-cycle launch pulse to all cores
//                core_entrada      core i word {bloque, nonce_i} in [128*i +: 128]
//                core_listo        per-core done flags
//                core_hash         core i hash in [24*i +: 24]
//                bounty_out        winning hash
//                nonce_out         winning nonce
//                terminado_out     job finished with a hit
//                agotado_out       job finished without a hit
//  Revision    : 1.0 - initial release
// ============================================================================
module micro_ucr_hash_scheduler
    import micro_ucr_pkg::*;
#(
    parameter int NUM_BLOQUES_PARALELOS = 4,
    parameter int MAX_RONDAS            = 1024
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       inicio,
    input  logic [BLOQUE_W-1:0]                        bloque_datos,
    input  logic [NONCE_W*NUM_BLOQUES_PARALELOS-1:0]   nonce_iniciales,
    input  logic [BYTE-1:0]                            target,
    output logic                                       core_start,
    output logic [ENTRADA_W*NUM_BLOQUES_PARALELOS-1:0] core_entrada,
    input  logic [NUM_BLOQUES_PARALELOS-1:0]           core_listo,
    input  logic [HASH_W*NUM_BLOQUES_PARALELOS-1:0]    core_hash,
    output logic [HASH_W-1:0]                          bounty_out,
    output logic [NONCE_W-1:0]                         nonce_out,
    output logic                                       terminado_out,
    output logic                                       agotado_out
);

    localparam int                   c_n       = NUM_BLOQUES_PARALELOS;
    localparam int                   c_idx_w   = (c_n > 1) ? $clog2(c_n) : 1;
    localparam int                   c_ronda_w = $clog2(MAX_RONDAS + 1);
    localparam logic [NONCE_W:0]     c_paso    = (NONCE_W+1)'(c_n);
    localparam logic [c_ronda_w-1:0] c_ultima  = c_ronda_w'(MAX_RONDAS - 1);

    logic [ST_W-1:0]      r_estado;
    logic [BLOQUE_W-1:0]  r_bloque;
    logic [BYTE-1:0]      r_target;
    logic [NONCE_W-1:0]   r_nonce [c_n];
    logic [c_ronda_w-1:0] r_ronda;
    logic                 r_core_start;
    logic [HASH_W-1:0]    r_bounty;
    logic [NONCE_W-1:0]   r_nonce_out;
    logic                 r_terminado;
    logic                 r_agotado;

    logic [c_n-1:0]       w_hit;
    logic [c_idx_w-1:0]   w_win_idx;
    logic [HASH_W-1:0]    w_win_hash;
    logic [NONCE_W:0]     w_suma [c_n];
    logic [c_n-1:0]       w_acarreo;

    micro_ucr_target_check #(
        .NUM_BLOQUES_PARALELOS (c_n),
        .IDX_W                 (c_idx_w)
    ) u_target_check (
        .i_hashes   (core_hash),
        .i_target   (r_target),
        .o_hit      (w_hit),
        .o_win_idx  (w_win_idx),
        .o_win_hash (w_win_hash)
    );

    // Next-round nonce per core; the extra bit flags a 32-bit wrap so the
    // wrapped value is never launched.
    for (genvar gi = 0; gi < c_n; gi++) begin : g_nonce
        assign w_suma[gi]    = {1'b0, r_nonce[gi]} + c_paso;
        assign w_acarreo[gi] = w_suma[gi][NONCE_W];
        assign core_entrada[ENTRADA_W*gi +: ENTRADA_W] = {r_bloque, r_nonce[gi]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_estado     <= S_IDLE;
            r_bloque     <= '0;
            r_target     <= '0;
            r_ronda      <= '0;
            r_core_start <= 1'b0;
            r_bounty     <= '0;
            r_nonce_out  <= '0;
            r_terminado  <= 1'b0;
            r_agotado    <= 1'b0;
            for (int i = 0; i < c_n; i++) begin
                r_nonce[i] <= '0;
            end
        end else begin
            r_core_start <= 1'b0;
            case (r_estado)
                S_IDLE: begin
                    if (inicio) begin
                        r_bloque <= bloque_datos;
                        r_target <= target;
                        r_ronda  <= '0;
                        for (int i = 0; i < c_n; i++) begin
                            r_nonce[i] <= nonce_iniciales[NONCE_W*i +: NONCE_W];
                        end
                        r_estado <= S_LANZA;
                    end
                end

                S_LANZA: begin
                    if (!inicio) begin
                        r_estado <= S_IDLE;
                    end else begin
                        r_core_start <= 1'b1;
                        r_estado     <= S_ESPERA;
                    end
                end

                // core_listo still shows the previous round while the start
                // pulse is out, so it is only trusted once the pulse is gone.
                S_ESPERA: begin
                    if (!inicio) begin
                        r_estado <= S_IDLE;
                    end else if (!r_core_start && (&core_listo)) begin
                        r_estado <= S_EVALUA;
                    end
                end

                S_EVALUA: begin
                    if (!inicio) begin
                        r_estado <= S_IDLE;
                    end else if (|w_hit) begin
                        r_bounty    <= w_win_hash;
                        r_nonce_out <= r_nonce[w_win_idx];
                        r_terminado <= 1'b1;
                        r_estado    <= S_EXITO;
                    end else if ((r_ronda == c_ultima) || (|w_acarreo)) begin
                        // This round was the last allowed one, or the next
                        // stride would wrap a nonce.
                        r_agotado <= 1'b1;
                        r_estado  <= S_AGOTADO;
                    end else begin
                        for (int i = 0; i < c_n; i++) begin
                            r_nonce[i] <= w_suma[i][NONCE_W-1:0];
                        end
                        r_ronda  <= r_ronda + c_ronda_w'(1);
                        r_estado <= S_LANZA;
                    end
                end

                S_EXITO, S_AGOTADO: begin
                    if (!inicio) begin
                        r_bounty    <= '0;
                        r_nonce_out <= '0;
                        r_terminado <= 1'b0;
                        r_agotado   <= 1'b0;
                        r_estado    <= S_IDLE;
                    end
                end

                default: r_estado <= S_IDLE;
            endcase
        end
    end

    assign core_start    = r_core_start;
    assign bounty_out    = r_bounty;
    assign nonce_out     = r_nonce_out;
    assign terminado_out = r_terminado;
    assign agotado_out   = r_agotado;

endmodule
`default_nettype wire
